// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for the N-bit up/down counter: sawtooth or triangle sweeps between
// latched limits, repeated a programmed number of times, with pause and abort.
//
// Handshake: start is sampled only in IDLE; a good job raises busy on the next cycle,
// a bad one (lo>hi) raises cfg_err for one cycle instead. done pulses for one cycle,
// with busy already low, after the last sweep completes normally. Abort drops busy
// with no done pulse.
module counter_sweep_ctrl #(
  parameter int N  = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  lo,
  input  logic [N-1:0]  hi,
  input  logic          mode,
  input  logic [LW-1:0] loops,
  input  logic          pause,
  input  logic          abort,
  output logic [N-1:0]  count,
  output logic          dir,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [LW-1:0] sweeps_done,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t        state_r, state_n;
  logic [N-1:0]  count_r, count_n;
  logic          dir_r, dir_n;
  logic          done_r, done_n;
  logic          cfg_err_r, cfg_err_n;
  logic [LW-1:0] sweeps_r, sweeps_n;

  // Job configuration, captured only when a start is accepted.
  logic [N-1:0]  lo_r, lo_n;
  logic [N-1:0]  hi_r, hi_n;
  logic          mode_r, mode_n;
  logic [LW-1:0] loops_r, loops_n;

  // One extra bit so sweeps+1 cannot wrap when compared against the loop count.
  logic [LW:0]   sweeps_inc;
  logic          last_sweep;

  assign sweeps_inc = {1'b0, sweeps_r} + {{LW{1'b0}}, 1'b1};
  assign last_sweep = !(sweeps_inc < {1'b0, loops_r});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= '0;
      dir_r     <= 1'b1;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      sweeps_r  <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
      mode_r    <= 1'b0;
      loops_r   <= {{(LW-1){1'b0}}, 1'b1};
    end else begin
      state_r   <= state_n;
      count_r   <= count_n;
      dir_r     <= dir_n;
      done_r    <= done_n;
      cfg_err_r <= cfg_err_n;
      sweeps_r  <= sweeps_n;
      lo_r      <= lo_n;
      hi_r      <= hi_n;
      mode_r    <= mode_n;
      loops_r   <= loops_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    dir_n     = dir_r;
    done_n    = 1'b0;
    cfg_err_n = 1'b0;
    sweeps_n  = sweeps_r;
    lo_n      = lo_r;
    hi_n      = hi_r;
    mode_n    = mode_r;
    loops_n   = loops_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          if (lo > hi) begin
            cfg_err_n = 1'b1;
          end else begin
            lo_n     = lo;
            hi_n     = hi;
            mode_n   = mode;
            loops_n  = (loops == '0) ? {{(LW-1){1'b0}}, 1'b1} : loops;
            count_n  = lo;
            dir_n    = 1'b1;
            sweeps_n = '0;
            state_n  = UP;
          end
        end
      end

      UP: begin
        if (abort) begin
          state_n = IDLE;
        end else if (!pause) begin
          if (count_r < hi_r) begin
            count_n = count_r + N'(1);
          end else if (mode_r && (hi_r > lo_r)) begin
            count_n = hi_r - N'(1);
            dir_n   = 1'b0;
            state_n = DOWN;
          end else begin
            // Top of a sawtooth, or a degenerate lo==hi sweep in either mode.
            sweeps_n = sweeps_inc[LW-1:0];
            if (last_sweep) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              count_n = lo_r;
              dir_n   = 1'b1;
            end
          end
        end
      end

      DOWN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (!pause) begin
          if (count_r > lo_r) begin
            count_n = count_r - N'(1);
          end else begin
            sweeps_n = sweeps_inc[LW-1:0];
            if (last_sweep) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              // Skip lo on the way back up so the turning value is not repeated.
              count_n = lo_r + N'(1);
              dir_n   = 1'b1;
              state_n = UP;
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign count       = count_r;
  assign dir         = dir_r;
  assign busy        = (state_r != IDLE);
  assign done        = done_r;
  assign cfg_err     = cfg_err_r;
  assign sweeps_done = sweeps_r;
  assign state_dbg   = state_r;

endmodule
